// File: rtl/kirby_anim_pkg.sv
// kirby_anim_pkg
//   Shared definitions for the Kirby sprite animation path: action codes,
//   per-action frame counts and one-shot flags (also used by the frame
//   mapper), and the sequencer FSM state encoding.
package kirby_anim_pkg;

    localparam int ACT_W       = 3;
    localparam int FRAME_W     = 4;
    localparam int NUM_ACTIONS = 3;

    typedef enum logic [ACT_W-1:0] {
        ACT_IDLE = 3'd0,
        ACT_WALK = 3'd1,
        ACT_JUMP = 3'd2
    } action_e;

    typedef enum logic {
        S_LOOP    = 1'b0,
        S_ONESHOT = 1'b1
    } state_e;

    localparam logic [FRAME_W-1:0] FRAME_COUNT [NUM_ACTIONS] = '{4'd2, 4'd10, 4'd10};
    localparam logic               ONE_SHOT    [NUM_ACTIONS] = '{1'b0, 1'b0, 1'b1};

    function automatic logic is_valid_action(input logic [ACT_W-1:0] a);
        return a < 3'(NUM_ACTIONS);
    endfunction

    // Index of the final frame of an action; 0 for codes outside the table.
    function automatic logic [FRAME_W-1:0] last_frame(input logic [ACT_W-1:0] a);
        case (a)
            3'd0:    return FRAME_COUNT[0] - 4'd1;
            3'd1:    return FRAME_COUNT[1] - 4'd1;
            3'd2:    return FRAME_COUNT[2] - 4'd1;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic is_one_shot(input logic [ACT_W-1:0] a);
        case (a)
            3'd0:    return ONE_SHOT[0];
            3'd1:    return ONE_SHOT[1];
            3'd2:    return ONE_SHOT[2];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kirby_anim_if.sv
// kirby_anim_if
//   Action request handshake between game logic and the animation sequencer.
//   A request is taken in any cycle where action_req_valid and
//   action_req_ready are both high.
//     action_req        : requested action code
//     action_req_valid  : request qualifier
//     action_req_ready  : sequencer can take a request
//   master = game logic, slave = sequencer.
interface kirby_anim_if;
    import kirby_anim_pkg::*;

    logic [ACT_W-1:0] action_req;
    logic             action_req_valid;
    logic             action_req_ready;

    modport master (output action_req, output action_req_valid, input  action_req_ready);
    modport slave  (input  action_req, input  action_req_valid, output action_req_ready);
endinterface

// File: rtl/frame_tick_sync.sv
// frame_tick_sync
//   Brings the asynchronous frame_clk into the clk domain with a 2-flop
//   synchroniser and emits a one-clk tick per rising edge.
//     clk       : system clock
//     rst_n     : asynchronous active-low reset
//     frame_clk : vsync-rate pulse, asynchronous to clk
//     tick      : one-cycle pulse per frame_clk rising edge
module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_clk,
    output logic tick
);
    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    // Stage 0/1: metastability filter; stage 2: previous level for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= frame_clk;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign tick = sync_p1 & ~prev_p2;
endmodule

// File: rtl/kirby_anim_sequencer.sv
// kirby_anim_sequencer
//   Turns action requests into the (action, frame) pair for the frame mapper.
//   Frames advance every HOLD_TICKS frame_clk edges; WALK and IDLE loop,
//   JUMP plays once, then returns to IDLE with a one-cycle anim_done pulse.
//   Ports:
//     Clk, Reset_n               : clock, asynchronous active-low reset
//     frame_clk                  : vsync-rate pacing pulse (asynchronous)
//     pause                      : freezes frame pacing (KIRBY_ANIM_PAUSE_EN only)
//     req_if                     : action request handshake (slave side)
//     character_action_idx       : current action
//     character_action_frame_idx : current frame within the action
//     anim_done                  : one-shot action finished
//   Build option: define KIRBY_ANIM_PAUSE_EN to add the pause input.
module kirby_anim_sequencer
    import kirby_anim_pkg::*;
#(
    parameter int HOLD_TICKS = 6
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
`ifdef KIRBY_ANIM_PAUSE_EN
    input  logic               pause,
`endif
    kirby_anim_if.slave        req_if,
    output logic [ACT_W-1:0]   character_action_idx,
    output logic [FRAME_W-1:0] character_action_frame_idx,
    output logic               anim_done
);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);

    logic tick;
    logic pause_i;

`ifdef KIRBY_ANIM_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    frame_tick_sync u_tick (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    state_e             state_q, state_d;
    logic [ACT_W-1:0]   act_q, act_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [3:0]         hold_q, hold_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               take_req;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_LOOP;
            act_q   <= ACT_IDLE;
            frame_q <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        // Invalid codes and repeats of the current action are accepted by the
        // handshake but change nothing, so they must not swallow a tick.
        take_req = req_if.action_req_valid && ready_q &&
                   is_valid_action(req_if.action_req) &&
                   (req_if.action_req != act_q);

        if (take_req) begin
            act_d   = req_if.action_req;
            frame_d = '0;
            hold_d  = '0;
            state_d = is_one_shot(req_if.action_req) ? S_ONESHOT : S_LOOP;
        end else if (tick && !pause_i) begin
            if (hold_q != HOLD_LAST) begin
                hold_d = hold_q + 4'd1;
            end else begin
                hold_d = '0;
                if (frame_q != last_frame(act_q)) begin
                    frame_d = frame_q + 4'd1;
                end else if (state_q == S_ONESHOT) begin
                    state_d = S_LOOP;
                    act_d   = ACT_IDLE;
                    frame_d = '0;
                    done_d  = 1'b1;
                end else begin
                    frame_d = '0;
                end
            end
        end

        ready_d = (state_d == S_LOOP);
    end

    assign req_if.action_req_ready    = ready_q;
    assign character_action_idx       = act_q;
    assign character_action_frame_idx = frame_q;
    assign anim_done                  = done_q;
endmodule

// File: tb/tb_kirby_anim_sequencer.sv
module tb_kirby_anim_sequencer;
    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic [2:0] character_action_idx;
    logic [3:0] character_action_frame_idx;
    logic       anim_done;
`ifdef KIRBY_ANIM_PAUSE_EN
    logic       pause;
`endif

    kirby_anim_if req_if ();

    kirby_anim_sequencer #(.HOLD_TICKS(6)) dut (
        .Clk                        (Clk),
        .Reset_n                    (Reset_n),
        .frame_clk                  (frame_clk),
`ifdef KIRBY_ANIM_PAUSE_EN
        .pause                      (pause),
`endif
        .req_if                     (req_if.slave),
        .character_action_idx       (character_action_idx),
        .character_action_frame_idx (character_action_frame_idx),
        .anim_done                  (anim_done)
    );

    always #5 Clk = ~Clk;

    // Observation word: {action[2:0], frame[3:0], anim_done, ready}
    logic [8:0] expq [$];
    logic [8:0] last_obs;
    bit         mon_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [8:0] obs_now();
        return {character_action_idx, character_action_frame_idx, anim_done,
                req_if.action_req_ready};
    endfunction

    function automatic logic [8:0] ex(input int a, input int f, input bit d, input bit r);
        return {3'(a), 4'(f), d, r};
    endfunction

    // Monitor: every change of the observed outputs is one DUT response.
    initial begin
        logic [8:0] cur;
        logic [8:0] e;
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                cur = obs_now();
                if (cur !== last_obs) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: actual=%h required=no change (prev %h)",
                                 cur, last_obs);
                    end else begin
                        e = expq.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL scoreboard@%0t: actual=%h required=%h", $time, cur, e);
                        end
                    end
                    last_obs = cur;
                end
            end
        end
    end

    // n frame_clk pulses, each high for hi Clk cycles; entered and left at posedge+1.
    task automatic frame_ticks(input int n, input int hi);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            repeat (hi) @(posedge Clk);
            #1 frame_clk = 1'b0;
            repeat (4) @(posedge Clk);
            #1;
        end
    endtask

    task automatic request(input logic [2:0] code);
        req_if.action_req       = code;
        req_if.action_req_valid = 1'b1;
        @(posedge Clk);
        #1 req_if.action_req_valid = 1'b0;
    endtask

    initial begin
        bit seen;
        Reset_n                 = 1'b0;
        frame_clk               = 1'b0;
        req_if.action_req       = 3'd0;
        req_if.action_req_valid = 1'b0;
`ifdef KIRBY_ANIM_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (obs_now() !== ex(0, 0, 0, 1)) begin
            errors++;
            $display("FAIL reset_state: actual=%h required=%h", obs_now(), ex(0, 0, 0, 1));
        end
        last_obs = ex(0, 0, 0, 1);
        mon_en   = 1'b1;
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        // IDLE loops 0,1,0 over 12 ticks
        expq.push_back(ex(0, 1, 0, 1));
        expq.push_back(ex(0, 0, 0, 1));
        frame_ticks(12, 2);

        // WALK: frames 1..9 then wrap, ready stays high
        expq.push_back(ex(1, 0, 0, 1));
        request(3'd1);
        for (int f = 1; f < 10; f++) expq.push_back(ex(1, f, 0, 1));
        expq.push_back(ex(1, 0, 0, 1));
        frame_ticks(60, 2);

        // Advance to WALK frame 4, partway into its hold
        for (int f = 1; f <= 4; f++) expq.push_back(ex(1, f, 0, 1));
        frame_ticks(26, 2);

        // JUMP; WALK request then held across the whole jump
        expq.push_back(ex(2, 0, 0, 0));
        for (int f = 1; f < 10; f++) expq.push_back(ex(2, f, 0, 0));
        expq.push_back(ex(0, 0, 1, 1));
        expq.push_back(ex(1, 0, 0, 1));
        req_if.action_req       = 3'd2;
        req_if.action_req_valid = 1'b1;
        @(posedge Clk);
        #1 req_if.action_req = 3'd1;
        frame_ticks(60, 2);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clk);
            if (character_action_idx == 3'd1) seen = 1'b1;
        end
        @(posedge Clk);
        #1 req_if.action_req_valid = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL held_walk_timeout: actual=act %0d required=act 1", character_action_idx);
        end

        // Invalid code and repeat of current action change nothing; 1-cycle pulses
        frame_ticks(3, 1);
        request(3'd5);
        expq.push_back(ex(1, 1, 0, 1));
        frame_ticks(3, 1);
        request(3'd1);
        expq.push_back(ex(1, 2, 0, 1));
        frame_ticks(6, 1);

        // Reset during JUMP frame 7: no anim_done
        expq.push_back(ex(2, 0, 0, 0));
        request(3'd2);
        for (int f = 1; f <= 7; f++) expq.push_back(ex(2, f, 0, 0));
        frame_ticks(42, 2);
        expq.push_back(ex(0, 0, 0, 1));
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        expq.push_back(ex(0, 1, 0, 1));
        frame_ticks(6, 2);

`ifdef KIRBY_ANIM_PAUSE_EN
        pause = 1'b1;
        frame_ticks(20, 2);
        pause = 1'b0;
`endif
        expq.push_back(ex(0, 0, 0, 1));
        frame_ticks(6, 2);

        for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge Clk);
        repeat (4) @(posedge Clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: actual=%0d outstanding required=0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
